// File: rtl/rc5_pkg.sv
// Shared constants, FSM state encoding and storage types for RC5 key expansion.
package rc5_pkg;

  localparam int unsigned WORD_W  = 16;
  localparam int unsigned MAX_T   = 34;
  localparam int unsigned C_WORDS = 8;
  localparam int unsigned IDX_W   = 6;
  localparam int unsigned JDX_W   = 3;
  localparam int unsigned ITER_W  = 7;
  localparam int unsigned ROT_W   = 4;

  localparam logic [WORD_W-1:0] P16 = 16'hB7E1;
  localparam logic [WORD_W-1:0] Q16 = 16'h9E37;

  typedef enum logic [1:0] {
    IDLE,
    INIT,
    MIX,
    FIN
  } state_e;

  typedef logic [WORD_W-1:0] s_array_t [MAX_T];
  typedef logic [WORD_W-1:0] l_array_t [C_WORDS];

endpackage

// File: rtl/rotl.sv
// 16-bit combinational rotate-left by a 4-bit amount.
module rotl (
  input  logic [15:0] din,
  input  logic [3:0]  amt,
  output logic [15:0] dout_c
);

  // Upper half of the doubled word shifted left is the rotated value.
  assign dout_c = 16'(({din, din} << amt) >> 16);

endmodule

// File: rtl/rc5_key_expand.sv
// RC5-16 key schedule: fills S[0..t-1] from a 128-bit key, one table operation per cycle.
module rc5_key_expand
  import rc5_pkg::*;
#(
  parameter int W     = 16,
  parameter int MAX_R = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [4:0]   num_rounds,
  input  logic [127:0] key,
  output logic         busy,
  output logic         done,
  output logic         keys_valid,
  input  logic [5:0]   sk_addr,
  output logic [W-1:0] sk_data
);

  state_e              state_q, state_d;
  s_array_t            s_q, s_d;
  l_array_t            l_q, l_d;
  logic [WORD_W-1:0]   a_q, a_d, b_q, b_d, p_q, p_d;
  logic [IDX_W-1:0]    idx_q, idx_d, t_q, t_d;
  logic [JDX_W-1:0]    j_q, j_d;
  logic [ITER_W-1:0]   iter_q, iter_d, n_q, n_d;
  logic                busy_q, busy_d, done_q, done_d, kv_q, kv_d;
  logic [W-1:0]        sk_data_q, sk_data_d;

  logic [4:0]          r_c;
  logic [IDX_W-1:0]    t_c, tmax_c;
  logic [WORD_W-1:0]   sum_a_c, a_new_c, ab_c, sum_b_c, b_new_c;

  // Round count clamp and derived table size / mix length.
  always_comb begin
    r_c    = (num_rounds > 5'(MAX_R)) ? 5'(MAX_R) : num_rounds;
    t_c    = {r_c, 1'b0} + 6'd2;
    tmax_c = (t_c < 6'(C_WORDS)) ? 6'(C_WORDS) : t_c;
  end

  // One mixing iteration datapath.
  always_comb begin
    sum_a_c = s_q[idx_q] + a_q + b_q;
    ab_c    = a_new_c + b_q;
    sum_b_c = l_q[j_q] + ab_c;
  end

  rotl u_rotl_a (
    .din    (sum_a_c),
    .amt    (4'd3),
    .dout_c (a_new_c)
  );

  rotl u_rotl_b (
    .din    (sum_b_c),
    .amt    (ab_c[ROT_W-1:0]),
    .dout_c (b_new_c)
  );

  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    l_d       = l_q;
    a_d       = a_q;
    b_d       = b_q;
    p_d       = p_q;
    idx_d     = idx_q;
    j_d       = j_q;
    iter_d    = iter_q;
    t_d       = t_q;
    n_d       = n_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    kv_d      = kv_q;
    sk_data_d = (sk_addr < 6'(MAX_T)) ? W'(s_q[sk_addr]) : '0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          for (int unsigned k = 0; k < C_WORDS; k++) begin
            l_d[k] = key[WORD_W*k +: WORD_W];
          end
          t_d     = t_c;
          n_d     = 7'(tmax_c) * 7'd3;
          p_d     = P16;
          idx_d   = '0;
          busy_d  = 1'b1;
          kv_d    = 1'b0;
          state_d = INIT;
        end
      end
      INIT: begin
        s_d[idx_q] = p_q;
        p_d        = p_q + Q16;
        if (idx_q == t_q - 6'd1) begin
          idx_d   = '0;
          j_d     = '0;
          a_d     = '0;
          b_d     = '0;
          iter_d  = '0;
          state_d = MIX;
        end else begin
          idx_d = idx_q + 6'd1;
        end
      end
      MIX: begin
        s_d[idx_q] = a_new_c;
        l_d[j_q]   = b_new_c;
        a_d        = a_new_c;
        b_d        = b_new_c;
        idx_d      = (idx_q + 6'd1 == t_q) ? '0 : idx_q + 6'd1;
        j_d        = j_q + 3'd1;
        iter_d     = iter_q + 7'd1;
        if (iter_q == n_q - 7'd1) begin
          state_d = FIN;
        end
      end
      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        kv_d    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and datapath registers; reset aborts any expansion in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      p_q       <= '0;
      idx_q     <= '0;
      j_q       <= '0;
      iter_q    <= '0;
      t_q       <= '0;
      n_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      kv_q      <= 1'b0;
      sk_data_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      p_q       <= p_d;
      idx_q     <= idx_d;
      j_q       <= j_d;
      iter_q    <= iter_d;
      t_q       <= t_d;
      n_q       <= n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      kv_q      <= kv_d;
      sk_data_q <= sk_data_d;
    end
  end

  // Subkey table and key words carry no reset.
  always_ff @(posedge clk) begin
    s_q <= s_d;
    l_q <= l_d;
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign keys_valid = kv_q;
  assign sk_data    = sk_data_q;

endmodule

// File: tb/tb_rc5_key_expand.sv
// Scoreboard bench for rc5_key_expand against a loop-level RC5-16 key schedule model.
module tb_rc5_key_expand;

  localparam int MAXT = 34;
  localparam logic [127:0] KSEQ = 128'h0F0E0D0C0B0A09080706050403020100;

  typedef struct {
    logic [15:0] s [MAXT];
    int          lat;
    int          acc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [4:0]   num_rounds = '0;
  logic [127:0] key = '0;
  logic [5:0]   sk_addr;
  logic [5:0]   stim_addr = '0;
  logic [5:0]   mon_addr = '0;
  logic         mon_owns = 1'b0;
  logic         busy, done, keys_valid;
  logic [15:0]  sk_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int issued = 0;
  int checked = 0;
  int busy_gap = 0;
  exp_t exp_q[$];
  logic [15:0] shadow [MAXT];

  assign sk_addr = mon_owns ? mon_addr : stim_addr;

  rc5_key_expand #(.W(16), .MAX_R(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_rounds (num_rounds),
    .key        (key),
    .busy       (busy),
    .done       (done),
    .keys_valid (keys_valid),
    .sk_addr    (sk_addr),
    .sk_data    (sk_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint got, input longint want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  function automatic logic [15:0] rl(input logic [15:0] x, input int n);
    logic [31:0] d;
    d = {x, x} << n;
    return d[31:16];
  endfunction

  // Textbook RC5 key schedule; updates shadow[0..t-1].
  task automatic model(input logic [127:0] k, input int nr);
    int r, t, nmix, i, j;
    logic [15:0] lw [8];
    logic [15:0] a, b;
    r = (nr > 16) ? 16 : nr;
    t = 2 * r + 2;
    for (int q = 0; q < t; q++) shadow[q] = 16'(32'hB7E1 + q * 32'h9E37);
    for (int q = 0; q < 8; q++) lw[q] = k[16*q +: 16];
    a = 0; b = 0; i = 0; j = 0;
    nmix = 3 * ((t > 8) ? t : 8);
    for (int q = 0; q < nmix; q++) begin
      a = rl(16'(shadow[i] + a + b), 3);
      shadow[i] = a;
      b = rl(16'(lw[j] + a + b), int'(16'(a + b) & 16'hF));
      lw[j] = b;
      i = (i + 1) % t;
      j = (j + 1) % 8;
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // mode: 0 plain, 1 peek INIT values, 2 disturb inputs mid-MIX, 3 reset abort mid-MIX
  task automatic run_job(input logic [127:0] k, input int nr, input int mode);
    exp_t e;
    int a0, t, r, guard;
    r = (nr > 16) ? 16 : nr;
    t = 2 * r + 2;
    @(negedge clk);
    key = k; num_rounds = 5'(nr); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a0 = cyc;
    chk("busy_after_start", busy, 1);
    chk("kv_cleared_on_start", keys_valid, 0);
    if (mode != 3) begin
      model(k, nr);
      e.s = shadow;
      e.lat = t + 3 * ((t > 8) ? t : 8) + 1;
      e.acc = a0;
      exp_q.push_back(e);
      issued++;
    end
    if (mode == 1) begin
      for (int q = 0; q < t && q < 4; q++) begin
        wait_cyc(a0 + t + q);
        stim_addr = 6'(q);
        wait_cyc(a0 + t + 1 + q);
        chk($sformatf("init_S%0d", q), sk_data, 16'(32'hB7E1 + q * 32'h9E37));
      end
    end else if (mode == 2) begin
      wait_cyc(a0 + t + 20);
      start = 1'b1;
      key = {$urandom, $urandom, $urandom, $urandom};
      num_rounds = 5'($urandom);
      @(negedge clk);
      start = 1'b0;
    end else if (mode == 3) begin
      wait_cyc(a0 + t + 39);
      rst = 1'b0;
      @(negedge clk);
      chk("abort_busy", busy, 0);
      chk("abort_kv", keys_valid, 0);
      chk("abort_done", done, 0);
      chk("abort_sk_data", sk_data, 0);
      rst = 1'b1;
      repeat (150) @(negedge clk);
    end
    if (mode != 3) begin
      guard = 0;
      while (checked != issued && guard < 1000) begin
        @(negedge clk);
        guard++;
      end
      if (checked != issued) begin
        failures++;
        $display("FAIL job_timeout r=%0d: done not seen within bound", nr);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    end
  endtask

  // Monitor: on every done pulse, pop expectation, check timing and read back the table.
  initial begin
    exp_t me;
    forever begin
      @(negedge clk);
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", done, 0);
        end else begin
          me = exp_q.pop_front();
          chk("latency", cyc - me.acc, me.lat);
          chk("busy_at_done", busy, 0);
          chk("kv_at_done", keys_valid, 1);
          chk("busy_held", busy_gap, 0);
          busy_gap = 0;
          mon_owns = 1'b1;
          for (int a = 0; a <= 40; a++) begin
            mon_addr = 6'(a);
            @(negedge clk);
            if (a == 0) chk("done_single_cycle", done, 0);
            chk($sformatf("S[%0d]", a), sk_data, (a < MAXT) ? me.s[a] : 16'h0);
          end
          mon_owns = 1'b0;
          checked++;
        end
      end else if (exp_q.size() != 0 && !busy) begin
        busy_gap++;
      end
    end
  end

  initial begin
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_kv", keys_valid, 0);
    chk("rst_sk_data", sk_data, 0);
    rst = 1'b1;

    run_job(128'h0, 16, 0);
    run_job(128'h0, 0, 1);
    run_job(KSEQ, 1, 1);
    run_job(128'h0, 12, 0);
    run_job(KSEQ, 12, 0);
    run_job(KSEQ, 0, 0);
    run_job(128'h0, 1, 0);
    run_job(KSEQ, 16, 0);
    run_job({$urandom, $urandom, $urandom, $urandom}, 20, 0);
    run_job({$urandom, $urandom, $urandom, $urandom}, 12, 2);
    run_job({$urandom, $urandom, $urandom, $urandom}, 12, 3);
    run_job({$urandom, $urandom, $urandom, $urandom}, 16, 0);
    for (int n = 0; n < 6; n++) begin
      run_job({$urandom, $urandom, $urandom, $urandom}, int'($urandom_range(0, 31)), n % 2 == 0 ? 0 : 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rc5_key_expand.md
RC5_KEY_EXPAND -- requirements
Module: rc5_key_expand

Interface
REQ-001 SHALL have parameter W, default 16, RC5 word width in bits; only 16 is supported.
REQ-002 SHALL have parameter MAX_R, default 16, the maximum number of rounds.
REQ-003 clk  input  1  clock; all logic on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  request key expansion; sampled only in IDLE.
REQ-006 num_rounds  input  5  round count r; values above 16 are treated as 16; latched when start is accepted.
REQ-007 key  input  128  secret key; L[i] = key[16i+15:16i] for i=0..7 (little-endian bytes); latched when start is accepted.
REQ-008 busy  output  1  high from start acceptance until done.
REQ-009 done  output  1  single-cycle pulse when the subkey table is complete.
REQ-010 keys_valid  output  1  high while the table holds a completed expansion.
REQ-011 sk_addr  input  6  subkey read address.
REQ-012 sk_data  output  16  registered value of S[sk_addr].

Function
REQ-013 SHALL compute t = 2r+2, with 2 <= t <= 34, and c = 8.
REQ-014 SHALL implement an FSM with states IDLE, INIT, MIX and FIN.
REQ-015 IDLE: start=1 SHALL latch key into L[0..7] and latch r, set busy=1, clear keys_valid and go to INIT with i=0.
REQ-016 INIT SHALL write one entry per cycle: S[0]=0xB7E1, then S[i]=S[i-1]+0x9E37 mod 2^16, for i=0..t-1; INIT SHALL last exactly t cycles.
REQ-017 On leaving INIT, the FSM SHALL set A=B=0 and i=j=0, and clear the iteration counter.
REQ-018 MIX SHALL perform one iteration per cycle for exactly 3*max(t,8) cycles, as follows:
- A' = ROTL(S[i]+A+B, 3); S[i] = A'.
- B' = ROTL(L[j]+A'+B, (A'+B) mod 16); L[j] = B'.
- i = (i+1 == t) ? 0 : i+1.
- j = (j+1) mod 8.
REQ-019 All additions SHALL be modulo 2^16, and the rotate amount SHALL be the low 4 bits of the sum.
REQ-020 After the last MIX iteration, the FSM SHALL enter FIN for one cycle with done=1, keys_valid set, and busy=0 from the next cycle; it then returns to IDLE.
REQ-021 Latency: done SHALL be asserted exactly t + 3*max(t,8) + 1 cycles after the accepting edge (r=12: 105 cycles; r=0: 27 cycles).
REQ-022 start SHALL be ignored while busy=1 or during FIN.
REQ-023 start in the same IDLE cycle as a read is legal; reads are non-blocking.
REQ-024 sk_data SHALL update one cycle after sk_addr is presented, in every state.
REQ-025 sk_data SHALL be 0 for sk_addr >= 34.
REQ-026 Entries with index >= t SHALL be left unchanged by expansion.
REQ-027 The r=0 edge case SHALL be handled: t=2 and 24 MIX cycles, with i wrapping every 2 cycles.
REQ-028 The r=16 edge case SHALL be handled: t=34, 102 MIX cycles, and i wrapping at 34.
REQ-029 A new start after done SHALL fully re-expand, overwriting S[0..t-1].
REQ-030 Changes on key and num_rounds after start acceptance SHALL have no effect.

Reset
REQ-031 rst=0 SHALL force IDLE with busy=0, done=0, keys_valid=0, sk_data=0, A=B=0 and all counters 0; the S and L contents need not be cleared.
REQ-032 rst=0 mid-INIT or mid-MIX SHALL abort the expansion, with keys_valid=0 and no done pulse.

Structure
REQ-033 Package rc5_pkg SHALL hold: P16=0xB7E1, Q16=0x9E37, MAX_T=34, C_WORDS=8, the FSM state enum, and the subkey array typedef.
REQ-034 Rotate-left SHALL reuse the existing rotl sub-module (16-bit data, 4-bit amount); no other sub-modules.
REQ-035 S SHALL be a 34x16 register file with one write port and two read ports (MIX index, sk_addr).

Verification
REQ-036 Init check: r=0, start, read S[0], S[1] after the INIT cycles -> 0xB7E1, 0x5618; for r=1, S[2] after INIT = 0xF44F.
REQ-037 Latency: r=12, any key -> done exactly 105 cycles after start; busy high throughout; done a single cycle.
REQ-038 Golden compare: key=0 and key=0x0F0E...0100 with r in {0,1,12,16} -> all S[0..t-1] match the C reference model bit-exact.
REQ-039 Ignore rules: start pulsed mid-MIX and key changed mid-MIX -> output is identical to an undisturbed run, with a single done.
REQ-040 Reset abort: rst=0 at MIX cycle 40 -> busy=0, keys_valid=0, no done; a subsequent start completes correctly.
REQ-041 Read port: sk_addr=40 -> sk_data=0 next cycle; num_rounds=20 -> behaves as r=16 (t=34, done at 137 cycles).
